vga_compositor: RTL and testbench
=================================

# vga_compositor

Owns the beam and the VGA pins. It generates the `beam_x`/`beam_y` raster that every sprite/layer block consumes, collects each layer's registered `color`/`is_transparent` answer, and resolves priority. It drives the final 12-bit RGB plus hsync/vsync, with sync delayed to match the layer pipeline. It sits at the top of the video path, between the layer blocks and the board DAC.

## Interface
Parameters:
- `H_VISIBLE`, 800: visible pixels per line.
- `H_FRONT`, 40: horizontal front porch, in clocks.
- `H_SYNC`, 128: hsync pulse width, in clocks.
- `H_BACK`, 88: horizontal back porch, in clocks.
- `V_VISIBLE`, 600: visible lines per frame.
- `V_FRONT`, 1: vertical front porch, in lines.
- `V_SYNC`, 4: vsync pulse width, in lines.
- `V_BACK`, 23: vertical back porch, in lines.
- `SYNC_ACTIVE_HIGH`, 1: sync polarity (1 = pulse high).
- `NUM_LAYERS`, 4: number of layer inputs; layer 0 has highest priority.
- `BG_COLOR`, 12'h000: background `{R,G,B}`, used when every layer is transparent.

Ports:
- `clk`  in  1  pixel clock, 40 MHz for the defaults.
- `rst`  in  1  synchronous, active-high reset.
- `beam_x`  out  11  current column, 0..H_TOTAL-1.
- `beam_y`  out  10  current line, 0..V_TOTAL-1.
- `frame_start`  out  1  one-cycle pulse while beam = (0,0).
- `layer_color`  in  [NUM_LAYERS-1:0][2:0][3:0]  per-layer color; channel 0=R, 1=G, 2=B.
- `layer_transparent`  in  NUM_LAYERS  1 = the layer does not cover this pixel.
- `vga_color`  out  [2:0][3:0]  pixel to the DAC; same channel order.
- `vga_hs`  out  1  horizontal sync.
- `vga_vs`  out  1  vertical sync.

## Operation
- H_TOTAL = sum of the H_* parameters (1056 for defaults). V_TOTAL = sum of the V_* parameters (628 for defaults).
- Beam counters:
  - `beam_x` increments every clock and wraps H_TOTAL-1 → 0.
  - On that wrap, `beam_y` increments and wraps V_TOTAL-1 → 0.
  - Both counters are registered outputs.
- Beam position is emitted during blanking too. Layers must answer transparent outside their own windows.
- Sync is a function of the beam at stage 0:
  - hs is active when H_VISIBLE+H_FRONT ≤ x < H_VISIBLE+H_FRONT+H_SYNC.
  - vs is active when V_VISIBLE+V_FRONT ≤ y < V_VISIBLE+V_FRONT+V_SYNC.
  - visible = (x < H_VISIBLE) && (y < V_VISIBLE).
- Pipeline (beam at stage 0):
  - Stage 1: layers present color/transparent for that beam position (their own register).
  - Stage 2: the compositor registers `vga_color`.
  - hs, vs and visible pass through a 2-deep shift register so that all outputs at stage 2 describe the same pixel.
- Priority mux at stage 2:
  - Select the lowest index i with `layer_transparent[i]`=0; output `layer_color[i]`.
  - If all layers are transparent, output BG_COLOR.
  - If the delayed visible bit is 0, output 12'h000, regardless of layers.
- `frame_start` is combinational from the counters: (beam_x==0 && beam_y==0). It is not delayed.

## Timing
- Reset values (held while `rst`=1, effective at the first clock edge with `rst` high):
  - beam_x=0, beam_y=0.
  - `vga_color`=0.
  - `vga_hs`/`vga_vs` inactive (0 if SYNC_ACTIVE_HIGH, else 1).
  - Both pipeline stages cleared to inactive/invisible.
  - `frame_start`=1, since the beam sits at (0,0).
- First clock after `rst` deasserts: beam_x=1. The first visible pixel reaches `vga_color` 2 cycles after beam (0,0).
- Latency from beam to `vga_color`/`vga_hs`/`vga_vs` is exactly 2 clocks.
- hsync active for exactly H_SYNC clocks per line. vsync active for exactly V_SYNC×H_TOTAL clocks per frame.
- Reset mid-frame: the counters jump to (0,0) on the next edge and the pipeline flushes. No partial sync pulse may be extended; sync goes inactive on that same edge.
- Line wrap and frame wrap occur on the same edge when (H_TOTAL-1, V_TOTAL-1) → (0,0).
- `frame_start` pulses exactly once per V_TOTAL×H_TOTAL clocks.

## Test plan
- Reset:
  - Stimulus: hold `rst` 3 cycles, then release.
  - Required response: during reset beam=(0,0), vga_color=0, hs=vs=0, frame_start=1. One clock after release beam_x=1 and frame_start=0.
- Horizontal timing (defaults):
  - Stimulus: run one full line.
  - Required response: beam_x wraps 1055→0 and beam_y increments. vga_hs is high for 128 clocks, starting 2 clocks after beam_x=840.
- Vertical timing:
  - Stimulus: run a full frame.
  - Required response: vga_vs is high across lines 601..604, delayed 2 clocks. frame_start period is 663168 clocks. beam_y wraps 627→0.
- Priority:
  - Stimulus: at beam (10,10), drive layer_transparent=4'b1010 with layer0=12'hF00, layer2=12'h0F0.
  - Required response: vga_color=12'hF00 two cycles later.
  - Stimulus: all transparent with BG_COLOR=12'h00F.
  - Required response: vga_color=12'h00F.
- Blanking:
  - Stimulus: at beam_x=900, drive layer0 opaque 12'hFFF.
  - Required response: vga_color=0 two cycles later.
- Mid-frame reset:
  - Stimulus: assert `rst` at beam (300,602) while vsync is active.
  - Required response: next edge gives beam=(0,0) and vs=0. After release, counting restarts from (0,0).

Source files
------------

// File: rtl/vga_compositor.sv
// vga_compositor: raster generator, layer priority resolver and VGA output stage.
// The beam counters form stage 0; layers answer at stage 1; colour and sync
// leave the block registered at stage 2, so every pin describes the same pixel.
module vga_compositor #(
    parameter int          H_VISIBLE        = 800,
    parameter int          H_FRONT          = 40,
    parameter int          H_SYNC           = 128,
    parameter int          H_BACK           = 88,
    parameter int          V_VISIBLE        = 600,
    parameter int          V_FRONT          = 1,
    parameter int          V_SYNC           = 4,
    parameter int          V_BACK           = 23,
    parameter int          SYNC_ACTIVE_HIGH = 1,
    parameter int          NUM_LAYERS       = 4,
    parameter logic [11:0] BG_COLOR         = 12'h000
) (
    input  logic                             clk,
    input  logic                             rst,
    output logic [10:0]                      beam_x,
    output logic [9:0]                       beam_y,
    output logic                             frame_start,
    input  logic [NUM_LAYERS-1:0][2:0][3:0]  layer_color,
    input  logic [NUM_LAYERS-1:0]            layer_transparent,
    output logic [2:0][3:0]                  vga_color,
    output logic                             vga_hs,
    output logic                             vga_vs
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = H_VISIBLE + H_FRONT + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = V_VISIBLE + V_FRONT + V_SYNC;

    // Sync level when no pulse is in progress.
    localparam logic SYNC_IDLE = (SYNC_ACTIVE_HIGH != 0) ? 1'b0 : 1'b1;

    // BG_COLOR is written {R,G,B}; the pixel bus puts R in channel 0.
    localparam logic [2:0][3:0] BG_CH = {BG_COLOR[3:0], BG_COLOR[7:4], BG_COLOR[11:8]};

    logic            hs_raw;
    logic            vs_raw;
    logic            vis_raw;
    logic            hs_d1;
    logic            vs_d1;
    logic            vis_d1;
    logic [2:0][3:0] pick;

    // Stage 0: beam counters; line and frame wrap share the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            beam_x <= '0;
            beam_y <= '0;
        end else if (beam_x == 11'(H_TOTAL - 1)) begin
            beam_x <= '0;
            if (beam_y == 10'(V_TOTAL - 1))
                beam_y <= '0;
            else
                beam_y <= beam_y + 10'd1;
        end else begin
            beam_x <= beam_x + 11'd1;
        end
    end

    assign frame_start = (beam_x == 11'd0) && (beam_y == 10'd0);

    assign hs_raw  = (beam_x >= 11'(HS_START)) && (beam_x < 11'(HS_END));
    assign vs_raw  = (beam_y >= 10'(VS_START)) && (beam_y < 10'(VS_END));
    assign vis_raw = (beam_x < 11'(H_VISIBLE)) && (beam_y < 10'(V_VISIBLE));

    // Stage 1: hold sync/visible while the layers compute their answer.
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_d1  <= 1'b0;
            vs_d1  <= 1'b0;
            vis_d1 <= 1'b0;
        end else begin
            hs_d1  <= hs_raw;
            vs_d1  <= vs_raw;
            vis_d1 <= vis_raw;
        end
    end

    // Priority mux: walk from the lowest priority up so layer 0 wins last.
    always_comb begin
        pick = BG_CH;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (!layer_transparent[i])
                pick = layer_color[i];
        end
    end

    // Stage 2: output registers; blanking forces black whatever the layers say.
    always_ff @(posedge clk) begin
        if (rst) begin
            vga_color <= '0;
            vga_hs    <= SYNC_IDLE;
            vga_vs    <= SYNC_IDLE;
        end else begin
            vga_color <= vis_d1 ? pick : '0;
            vga_hs    <= hs_d1 ? ~SYNC_IDLE : SYNC_IDLE;
            vga_vs    <= vs_d1 ? ~SYNC_IDLE : SYNC_IDLE;
        end
    end

endmodule

// File: tb/tb_vga_compositor.sv
// Scoreboard bench for vga_compositor on a reduced 25x17 raster
// (visible 16x12, hsync x=18..21, vsync y=13..14, background 12'h00F).
module tb_vga_compositor;

    logic                  clk;
    logic                  rst;
    logic [10:0]           beam_x;
    logic [9:0]            beam_y;
    logic                  frame_start;
    logic [3:0][2:0][3:0]  layer_color;
    logic [3:0]            layer_transparent;
    logic [2:0][3:0]       vga_color;
    logic                  vga_hs;
    logic                  vga_vs;

    vga_compositor #(
        .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
        .V_VISIBLE(12), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
        .SYNC_ACTIVE_HIGH(1), .NUM_LAYERS(4), .BG_COLOR(12'h00F)
    ) dut (
        .clk(clk), .rst(rst), .beam_x(beam_x), .beam_y(beam_y),
        .frame_start(frame_start), .layer_color(layer_color),
        .layer_transparent(layer_transparent), .vga_color(vga_color),
        .vga_hs(vga_hs), .vga_vs(vga_vs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          tag;
        int          x;
        int          y;
        logic        fs;
    } beam_t;

    typedef struct {
        int          tag;
        logic [11:0] color;
        logic        hs;
        logic        vs;
    } pix_t;

    typedef struct {
        int          x;
        int          y;
        logic [3:0]  tr;
        logic [11:0] c0;
        logic [11:0] c1;
        logic [11:0] c2;
        logic [11:0] c3;
        logic [11:0] exp;
    } vec_t;

    beam_t bq[$];
    pix_t  pq[$];
    vec_t  vecs[9];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [2:0][3:0] to_ch(input logic [11:0] rgb);
        return {rgb[3:0], rgb[7:4], rgb[11:8]};
    endfunction

    function automatic logic [11:0] from_ch(input logic [2:0][3:0] c);
        return {c[0], c[1], c[2]};
    endfunction

    task automatic chk(input string name, input int cyc, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: compares whatever the scoreboard expects for this cycle.
    initial begin
        int    mcyc;
        beam_t b;
        pix_t  p;
        mcyc = 0;
        forever begin
            @(negedge clk);
            mcyc++;
            if (bq.size() > 0 && bq[0].tag == mcyc) begin
                b = bq.pop_front();
                chk("beam_x", mcyc, int'(beam_x), b.x);
                chk("beam_y", mcyc, int'(beam_y), b.y);
                chk("frame_start", mcyc, int'(frame_start), int'(b.fs));
            end
            if (pq.size() > 0 && pq[0].tag == mcyc) begin
                p = pq.pop_front();
                chk("vga_color", mcyc, int'(from_ch(vga_color)), int'(p.color));
                chk("vga_hs", mcyc, int'(vga_hs), int'(p.hs));
                chk("vga_vs", mcyc, int'(vga_vs), int'(p.vs));
            end
        end
    end

    // Stimulus: bench-owned beam model plus directed layer vectors.
    int   scyc;
    int   mx, my, px, py;
    logic prst;

    function automatic int find_vec(input int x, input int y);
        for (int k = 0; k < 9; k++)
            if (vecs[k].x == x && vecs[k].y == y) return k;
        return -1;
    endfunction

    task automatic tick(input logic r);
        int          k;
        int          nx, ny;
        logic [11:0] ecol;
        pix_t        p;
        beam_t       b;
        rst = r;
        // Layers answer for the beam seen one cycle ago (their own register).
        k = find_vec(px, py);
        if (k >= 0) begin
            layer_transparent = vecs[k].tr;
            layer_color[0] = to_ch(vecs[k].c0);
            layer_color[1] = to_ch(vecs[k].c1);
            layer_color[2] = to_ch(vecs[k].c2);
            layer_color[3] = to_ch(vecs[k].c3);
            ecol = vecs[k].exp;
        end else begin
            layer_transparent = 4'hF;
            layer_color[0] = to_ch(12'h123);
            layer_color[1] = to_ch(12'h456);
            layer_color[2] = to_ch(12'h789);
            layer_color[3] = to_ch(12'hABC);
            ecol = (px < 16 && py < 12) ? 12'h00F : 12'h000;
        end
        p.tag = scyc + 1;
        if (r || prst) begin
            p.color = 12'h000;
            p.hs    = 1'b0;
            p.vs    = 1'b0;
        end else begin
            p.color = ecol;
            p.hs    = (px >= 18 && px < 22);
            p.vs    = (py >= 13 && py < 15);
        end
        pq.push_back(p);
        if (r) begin
            nx = 0;
            ny = 0;
        end else if (mx == 24) begin
            nx = 0;
            ny = (my == 16) ? 0 : my + 1;
        end else begin
            nx = mx + 1;
            ny = my;
        end
        b.tag = scyc + 1;
        b.x   = nx;
        b.y   = ny;
        b.fs  = (nx == 0 && ny == 0);
        bq.push_back(b);
        px = mx;
        py = my;
        mx = nx;
        my = ny;
        prst = r;
        @(negedge clk);
        scyc++;
    endtask

    initial begin
        int guard;
        vecs[0] = '{10, 10, 4'b1010, 12'hF00, 12'h111, 12'h0F0, 12'h222, 12'hF00};
        vecs[1] = '{11, 10, 4'b1111, 12'hF00, 12'h111, 12'h0F0, 12'h222, 12'h00F};
        vecs[2] = '{12, 10, 4'b1101, 12'hAAA, 12'h0A5, 12'hBBB, 12'hCCC, 12'h0A5};
        vecs[3] = '{13, 10, 4'b0111, 12'hAAA, 12'h0A5, 12'hBBB, 12'h3C3, 12'h3C3};
        vecs[4] = '{15, 11, 4'b0000, 12'hABC, 12'h0A5, 12'hBBB, 12'h3C3, 12'hABC};
        vecs[5] = '{16, 11, 4'b1110, 12'hFFF, 12'h0A5, 12'hBBB, 12'h3C3, 12'h000};
        vecs[6] = '{0,  0,  4'b1110, 12'h5A5, 12'h0A5, 12'hBBB, 12'h3C3, 12'h5A5};
        vecs[7] = '{20, 10, 4'b1110, 12'hFFF, 12'h0A5, 12'hBBB, 12'h3C3, 12'h000};
        vecs[8] = '{5,  12, 4'b1110, 12'hFFF, 12'h0A5, 12'hBBB, 12'h3C3, 12'h000};

        rst = 1'b1;
        layer_transparent = 4'hF;
        layer_color = '0;
        mx = 0; my = 0; px = 0; py = 0; prst = 1'b1;
        @(negedge clk);
        scyc = 1;

        for (int i = 0; i < 3; i++) tick(1'b1);
        for (int i = 0; i < 445; i++) tick(1'b0);

        // Run into vsync of the second frame, then reset mid-pulse.
        guard = 0;
        while (!(mx == 5 && my == 13) && guard < 1000) begin
            tick(1'b0);
            guard++;
        end
        n_checks++;
        if (guard >= 1000) begin
            n_fail++;
            $display("FAIL mid_frame_reach: beam model never reached (5,13), expected within 1000 cycles");
        end
        tick(1'b1);
        tick(1'b1);
        for (int i = 0; i < 440; i++) tick(1'b0);

        @(negedge clk);
        #1;
        chk("beam_queue_drained", scyc, bq.size(), 0);
        chk("pixel_queue_drained", scyc, pq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
